cla_sub16_pipe: RTL and testbench

CLA_SUB16_PIPE -- requirements
Module: cla_sub16_pipe

---
 rtl/cla_pkg.sv | 14 +
 rtl/cla_4bit_grp.sv | 40 ++++
 rtl/cla_sub16_pipe.sv | 124 ++++++++++++
 tb/tb_cla_sub16_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
//------------------------------------------------------------------------------
// Module      : cla_pkg
// Description : Shared sizing constants for the carry-lookahead adder family.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cla_pkg;
   localparam int WIDTH   = 16;
   localparam int GROUP   = 4;
   localparam int NGROUPS = 4;
endpackage : cla_pkg

`default_nettype wire

// File: rtl/cla_4bit_grp.sv
//------------------------------------------------------------------------------
// Module      : cla_4bit_grp
// Description : 4-bit carry-lookahead group with group propagate/generate.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cla_4bit_grp
   import cla_pkg::*;
(
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] s,
   output logic             P,
   output logic             G
);

   logic [GROUP-1:0] w_p;
   logic [GROUP-1:0] w_g;
   logic [GROUP-1:0] w_c;

   assign w_p = a ^ b;
   assign w_g = a & b;

   // Every internal carry is a flat sum of products of cin; nothing ripples.
   assign w_c[0] = cin;
   assign w_c[1] = w_g[0] | (w_p[0] & cin);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & cin);

   assign s = w_p ^ w_c;
   assign P = &w_p;
   assign G = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : cla_4bit_grp

`default_nettype wire

// File: rtl/cla_sub16_pipe.sv
//------------------------------------------------------------------------------
// Module      : cla_sub16_pipe
// Description : Two-stage valid/ready pipelined 16-bit CLA subtractor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cla_sub16_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = cla_pkg::WIDTH
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V,
   output logic             Z
);

   localparam int HALF = (NGROUPS / 2) * GROUP;

   // Stage 1: low byte as A + ~B + ~Bin
   logic [WIDTH-1:0] w_nb;
   logic             w_c0, w_c4, w_c8;
   logic [GROUP-1:0] w_s0, w_s1;
   logic             w_p0, w_g0, w_p1, w_g1;

   assign w_nb = ~B;
   assign w_c0 = ~Bin;

   cla_4bit_grp u_grp0 (.a(A[GROUP-1:0]),    .b(w_nb[GROUP-1:0]),    .cin(w_c0), .s(w_s0), .P(w_p0), .G(w_g0));
   cla_4bit_grp u_grp1 (.a(A[HALF-1:GROUP]), .b(w_nb[HALF-1:GROUP]), .cin(w_c4), .s(w_s1), .P(w_p1), .G(w_g1));

   assign w_c4 = w_g0 | (w_p0 & w_c0);
   assign w_c8 = w_g1 | (w_p1 & w_g0) | (w_p1 & w_p0 & w_c0);

   logic [HALF-1:0] r_a_hi, r_nb_hi, r_d_lo;
   logic            r_a15, r_b15, r_c8, r_s1_valid;

   // Stage 2: high byte from registered operands and c8
   logic [GROUP-1:0] w_s2, w_s3;
   logic             w_p2, w_g2, w_p3, w_g3;
   logic             w_c12, w_c16;
   logic [WIDTH-1:0] w_d;

   cla_4bit_grp u_grp2 (.a(r_a_hi[GROUP-1:0]),    .b(r_nb_hi[GROUP-1:0]),    .cin(r_c8),  .s(w_s2), .P(w_p2), .G(w_g2));
   cla_4bit_grp u_grp3 (.a(r_a_hi[HALF-1:GROUP]), .b(r_nb_hi[HALF-1:GROUP]), .cin(w_c12), .s(w_s3), .P(w_p3), .G(w_g3));

   assign w_c12 = w_g2 | (w_p2 & r_c8);
   assign w_c16 = w_g3 | (w_p3 & w_g2) | (w_p3 & w_p2 & r_c8);
   assign w_d   = {w_s3, w_s2, r_d_lo};

   logic [WIDTH-1:0] r_d;
   logic             r_bout, r_v, r_z, r_s2_valid;

   // Handshake: s1 may refill in the same cycle it hands over to s2
   logic w_s2_load, w_accept;

   assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
   assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
   assign w_accept  = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_a_hi     <= '0;
         r_nb_hi    <= '0;
         r_d_lo     <= '0;
         r_a15      <= 1'b0;
         r_b15      <= 1'b0;
         r_c8       <= 1'b0;
      end else begin
         if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_a_hi     <= A[WIDTH-1:HALF];
            r_nb_hi    <= w_nb[WIDTH-1:HALF];
            r_d_lo     <= {w_s1, w_s0};
            r_a15      <= A[WIDTH-1];
            r_b15      <= B[WIDTH-1];
            r_c8       <= w_c8;
         end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_d        <= '0;
         r_bout     <= 1'b0;
         r_v        <= 1'b0;
         r_z        <= 1'b0;
      end else begin
         if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_d        <= w_d;
            r_bout     <= ~w_c16;
            r_v        <= (r_a15 != r_b15) && (w_d[WIDTH-1] != r_a15);
            r_z        <= (w_d == '0);
         end else if (out_ready) begin
            r_s2_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign D         = r_d;
   assign Bout      = r_bout;
   assign V         = r_v;
   assign Z         = r_z;

endmodule : cla_sub16_pipe

`default_nettype wire

// File: tb/tb_cla_sub16_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_cla_sub16_pipe
// Description : Self-checking bench for cla_sub16_pipe against an arithmetic model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cla_sub16_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        Bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] D;
   logic        Bout, V, Z;

   int n_checks = 0;
   int n_fail   = 0;

   // {Bout, V, Z, D}
   typedef logic [18:0] res_t;
   res_t exp_q[$];

   always #5 clk = ~clk;

   cla_sub16_pipe #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Bout      (Bout),
      .V         (V),
      .Z         (Z)
   );

   // Unsigned and signed integer differences; overflow is leaving the 16-bit signed range.
   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
      int          ud, sd;
      logic [15:0] d;
      ud = int'(a) - int'(b) - int'(bin);
      sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
      d  = ud[15:0];
      return {ud < 0, (sd < -32768) || (sd > 32767), d == 16'h0000, d};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      n_checks++;
      if ({Bout, V, Z, D} !== 19'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {Bout, V, Z, D});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_directed();
      logic [15:0] ta [4] = '{16'h0005, 16'h0000, 16'h8000, 16'h1234};
      logic [15:0] tb [4] = '{16'h0003, 16'h0001, 16'h0001, 16'h1233};
      logic        tbi[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      res_t        te [4] = '{{3'b000, 16'h0002}, {3'b100, 16'hFFFF},
                              {3'b010, 16'h7FFF}, {3'b001, 16'h0000}};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         A = ta[i]; B = tb[i]; Bin = tbi[i];
         in_valid = 1'b1; out_ready = 1'b1;
         #1;
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready);
         end
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL dir%0d_early: out_valid=%b expected 0 after 1 cycle", i, out_valid);
         end
         @(negedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || {Bout, V, Z, D} !== te[i]) begin
            n_fail++;
            $display("FAIL dir%0d_result: valid=%b {Bout,V,Z,D}=%h expected valid=1 %h",
                     i, out_valid, {Bout, V, Z, D}, te[i]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [32:0] items[4];
      int   idx  = 0;
      int   got  = 0;
      logic held = 1'b0;
      res_t held_val = '0;
      res_t e;
      exp_q.delete();
      for (int i = 0; i < 4; i++) items[i] = {16'($urandom), 16'($urandom), 1'($urandom)};
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 3);
         in_valid  = (idx < 4);
         if (idx < 4) {A, B, Bin} = items[idx];
         #1;
         if (cyc < 3) begin
            n_checks++;
            if (in_ready !== (cyc < 2) || idx != cyc - (cyc == 2 ? 0 : 0) && cyc < 2 && idx != cyc) begin
               n_fail++;
               $display("FAIL b2b_in_ready_c%0d: got %b expected %b (accepted %0d)",
                        cyc, in_ready, cyc < 2, idx);
            end
         end
         if (cyc == 2) begin
            n_checks++;
            if (idx != 2) begin
               n_fail++;
               $display("FAIL b2b_accepted: got %0d expected 2", idx);
            end
         end
         if (held) begin
            n_checks++;
            if ({Bout, V, Z, D} !== held_val || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL b2b_hold: got %h expected %h", {Bout, V, Z, D}, held_val);
            end
         end
         held     = out_valid && !out_ready;
         held_val = {Bout, V, Z, D};
         if (in_valid && in_ready) begin
            exp_q.push_back(model(A, B, Bin));
            idx++;
         end
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_spurious: got %h expected no output", {Bout, V, Z, D});
            end else begin
               e = exp_q.pop_front();
               if ({Bout, V, Z, D} !== e) begin
                  n_fail++;
                  $display("FAIL b2b_result%0d: got %h expected %h", got, {Bout, V, Z, D}, e);
               end
            end
            got++;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (got != 4) begin
         n_fail++;
         $display("FAIL b2b_timeout: got %0d results expected 4", got);
      end
   endtask

   task automatic test_reset_midflight();
      exp_q.delete();
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      @(negedge clk);
      A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_full: out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || D !== 16'h0000 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset: out_valid=%b D=%h in_ready=%b expected 0/0000/1",
                  out_valid, D, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale%0d: out_valid=%b expected 0", i, out_valid);
         end
      end
   endtask

   task automatic test_random();
      int   accepted = 0;
      int   received = 0;
      int   cyc = 0;
      logic held = 1'b0;
      res_t held_val = '0;
      res_t e;
      exp_q.delete();
      while ((accepted < 10000 || exp_q.size() > 0) && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         in_valid  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
         A = 16'($urandom); B = 16'($urandom); Bin = 1'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         n_checks++;
         if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
            n_fail++;
            $display("FAIL rnd_in_ready: got %b expected %b (in flight %0d)",
                     in_ready, (exp_q.size() < 2) || out_ready, exp_q.size());
         end
         if (held) begin
            n_checks++;
            if ({Bout, V, Z, D} !== held_val || out_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL rnd_hold: got %h expected %h", {Bout, V, Z, D}, held_val);
            end
         end
         held     = out_valid && !out_ready;
         held_val = {Bout, V, Z, D};
         if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rnd_spurious: got %h expected no output", {Bout, V, Z, D});
            end else begin
               e = exp_q.pop_front();
               if ({Bout, V, Z, D} !== e) begin
                  n_fail++;
                  $display("FAIL rnd_result%0d: got %h expected %h", received, {Bout, V, Z, D}, e);
               end
            end
            received++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(A, B, Bin));
            accepted++;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (accepted != 10000 || received != 10000 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rnd_drain: accepted %0d received %0d pending %0d expected 10000/10000/0",
                  accepted, received, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_cla_sub16_pipe

`default_nettype wire
